immu_ptw_responder: RTL and testbench
=====================================

# immu_ptw_responder

Responder for the instruction MMU's page-table-walk read channel. It accepts single 64-bit PTE read requests on the AR channel, returns data on the R channel, and fetches misses from memory through a single-beat AXI-style read master. A one-entry PTE buffer serves repeated reads of the same doubleword without a memory access. It sits on the dcache side, between the instruction MMU and the memory read port.

## Interface
- No parameters.
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- immu_arvalid  input  1  request valid
- immu_arready  output  1  request accepted
- immu_aruser  input  1  1 = bypass PTE buffer (force memory fetch)
- immu_araddr  input  64  PTE physical byte address
- immu_rvalid  output  1  response valid
- immu_rready  input  1  response accepted
- immu_rresp  output  2  00 OKAY, 10 SLVERR; memory resp passed through otherwise
- immu_rdata  output  64  PTE data
- flush_valid  input  1  invalidate PTE buffer request
- flush_ready  output  1  invalidate accepted
- mem_arvalid  output  1  memory read request
- mem_arready  input  1
- mem_araddr  output  64  8-byte-aligned address
- mem_rvalid  input  1
- mem_rready  output  1
- mem_rresp  input  2
- mem_rdata  input  64

## Operation
- FSM states: IDLE, MEM_AR, MEM_R, RESP; reset state IDLE.
- Buffer: buf_valid, buf_tag[60:0] (address bits 63:3), buf_data[63:0]; reset buf_valid=0.
- IDLE: flush_ready=1; immu_arready = !flush_valid (flush wins over a simultaneous request).
  - Flush handshake: buf_valid<=0; stay IDLE.
  - AR handshake: latch araddr and aruser, then:
    - araddr[2:0]!=0: respond rresp=10, rdata=0, no memory access -> RESP.
    - Hit (buf_valid & buf_tag==araddr[63:3] & !aruser): rresp=00, rdata=buf_data -> RESP.
    - Otherwise -> MEM_AR.
- MEM_AR: mem_arvalid=1; mem_araddr={latched[63:3],3'b000}, stable until handshake; on mem_arready -> MEM_R.
- MEM_R: mem_rready=1; on mem_rvalid capture mem_rdata and mem_rresp into the response registers.
  - If mem_rresp==00: buf_valid<=1, buf_tag and buf_data updated.
  - Else: buf_valid<=0.
  - -> RESP.
- RESP: immu_rvalid=1; rdata and rresp held stable until rready; on handshake -> IDLE.
- Outside IDLE, flush_ready=0 and immu_arready=0; a pending flush waits for IDLE.
- aruser=1 miss refills the buffer like any other miss.

## Timing
- Reset values: immu_rvalid=0, immu_rresp=00, immu_rdata=0, mem_arvalid=0, mem_araddr=0, mem_rready=0. immu_arready=!flush_valid and flush_ready=1, since they decode from IDLE.
- Hit or misaligned request: AR handshake in cycle N, immu_rvalid=1 in N+1.
- Miss: AR handshake in N, mem_arvalid=1 in N+1.
  - With mem_arready in N+1, mem_rready=1 from N+2.
  - mem_rvalid in cycle M gives immu_rvalid=1 in M+1.
- Back-to-back: after the R handshake in cycle K, immu_arready=1 in K+1. Throughput is one request per 2 cycles on hits.
- One request outstanding at most; no AR is accepted while a response is pending.
- rvalid and mem_arvalid never drop before their handshake.
- Reset mid-operation: immediate return to IDLE, buffer invalid, all outputs at reset values, any in-flight memory beat abandoned.

## Test plan
- Miss then hit:
  - Read 0x8000_1000; memory returns 0x0000_0000_2000_0C01, OKAY.
  - Expect one mem_arvalid with mem_araddr=0x8000_1000 and rdata=0x...2000_0C01.
  - Repeat the read: rvalid in N+1, no mem_arvalid, same data.
- Bypass: read 0x8000_1000 with aruser=1 after a fill. Expect a memory access and the buffer refilled with the new data.
- Misaligned read of 0x8000_1004. Expect rresp=10, rdata=0, no mem_arvalid, buffer state unchanged.
- Memory error: mem_rresp=10 on a miss. Expect rresp=10 to the MMU, buf_valid=0, and the next read of the same address goes to memory.
- Flush:
  - flush_valid and arvalid asserted together in IDLE: flush accepted first, arready=0 that cycle; the following read misses.
  - flush_valid asserted during MEM_R: flush_ready stays 0 until IDLE.
- Backpressure and reset:
  - rready held low 5 cycles: rvalid, rdata and rresp stay stable.
  - rst_n pulsed in MEM_AR: mem_arvalid=0 immediately; the next read of the previously buffered address misses.

Source files
------------

// File: rtl/immu_ptw_responder_if.sv
// immu_ptw_responder_if: MMU-side PTE read channel, PTE buffer
// flush handshake and the single-beat memory read channel.
interface immu_ptw_responder_if;
    logic        immu_arvalid;
    logic        immu_arready;
    logic        immu_aruser;
    logic [63:0] immu_araddr;
    logic        immu_rvalid;
    logic        immu_rready;
    logic [1:0]  immu_rresp;
    logic [63:0] immu_rdata;
    logic        flush_valid;
    logic        flush_ready;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [63:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [1:0]  mem_rresp;
    logic [63:0] mem_rdata;

    modport slave (
        input  immu_arvalid, immu_aruser, immu_araddr,
        input  immu_rready, flush_valid,
        input  mem_arready, mem_rvalid, mem_rresp, mem_rdata,
        output immu_arready, immu_rvalid, immu_rresp,
        output immu_rdata, flush_ready,
        output mem_arvalid, mem_araddr, mem_rready
    );

    modport master (
        output immu_arvalid, immu_aruser, immu_araddr,
        output immu_rready, flush_valid,
        output mem_arready, mem_rvalid, mem_rresp, mem_rdata,
        input  immu_arready, immu_rvalid, immu_rresp,
        input  immu_rdata, flush_ready,
        input  mem_arvalid, mem_araddr, mem_rready
    );
endinterface

// File: rtl/immu_ptw_responder.sv
// immu_ptw_responder: IMMU page-table-walk read responder with a
// one-entry PTE buffer in front of a single-beat memory read port.
module immu_ptw_responder (
    input  logic                  clk,
    input  logic                  rst_n,
    immu_ptw_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_AR = 2'd1,
        MEM_R  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        buf_valid;
    logic [60:0] buf_tag;
    logic [63:0] buf_data;
    logic [60:0] req_tag;
    logic [63:0] resp_data;
    logic [1:0]  resp_code;

    logic        ar_fire;
    logic        misaligned;
    logic        hit;

    // Request decode: flush takes priority over a same-cycle request.
    always_comb begin
        ar_fire    = (state == IDLE) && !bus.flush_valid
                     && bus.immu_arvalid;
        misaligned = (bus.immu_araddr[2:0] != 3'b000);
        hit        = buf_valid && !bus.immu_aruser
                     && (buf_tag == bus.immu_araddr[63:3]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ar_fire)
                    state_nxt = (misaligned || hit) ? RESP : MEM_AR;
            end
            MEM_AR: if (bus.mem_arready) state_nxt = MEM_R;
            MEM_R:  if (bus.mem_rvalid)  state_nxt = RESP;
            RESP:   if (bus.immu_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state and held registers.
    always_comb begin
        bus.flush_ready  = (state == IDLE);
        bus.immu_arready = (state == IDLE) && !bus.flush_valid;
        bus.mem_arvalid  = (state == MEM_AR);
        bus.mem_rready   = (state == MEM_R);
        bus.immu_rvalid  = (state == RESP);
        bus.mem_araddr   = {req_tag, 3'b000};
        bus.immu_rdata   = resp_data;
        bus.immu_rresp   = resp_code;
    end

    // Request latch, response registers and PTE buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            req_tag   <= '0;
            resp_data <= '0;
            resp_code <= 2'b00;
        end else begin
            if (state == IDLE && bus.flush_valid) begin
                buf_valid <= 1'b0;
            end else if (ar_fire) begin
                req_tag <= bus.immu_araddr[63:3];
                if (misaligned) begin
                    resp_code <= 2'b10;
                    resp_data <= '0;
                end else if (hit) begin
                    resp_code <= 2'b00;
                    resp_data <= buf_data;
                end
            end
            if (state == MEM_R && bus.mem_rvalid) begin
                resp_code <= bus.mem_rresp;
                resp_data <= bus.mem_rdata;
                if (bus.mem_rresp == 2'b00) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= req_tag;
                    buf_data  <= bus.mem_rdata;
                end else begin
                    buf_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_immu_ptw_responder.sv
// tb_immu_ptw_responder: directed-vector bench for the IMMU PTW
// responder, with hand-computed expected responses.
module tb_immu_ptw_responder;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   mem_hs;

    immu_ptw_responder_if bus ();

    immu_ptw_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory AR handshakes seen by the bench.
    always @(posedge clk)
        if (rst_n && bus.mem_arvalid && bus.mem_arready)
            mem_hs <= mem_hs + 1;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full read. Inputs change at negedge, outputs are sampled
    // #1 later, so every posedge sees settled values.
    task automatic do_read(input string tag,
                           input logic [63:0] a,
                           input logic u,
                           input logic miss,
                           input logic [63:0] md,
                           input logic [1:0] mr,
                           input logic [63:0] ed,
                           input logic [1:0] er,
                           input int hold,
                           input logic fl);
        int hs0;
        hs0 = mem_hs;
        @(negedge clk);
        bus.immu_arvalid = 1'b1;
        bus.immu_araddr  = a;
        bus.immu_aruser  = u;
        #1 chk({tag, ".arready"}, 64'(bus.immu_arready), 64'd1);
        @(negedge clk);
        bus.immu_arvalid = 1'b0;
        #1;
        if (miss) begin
            chk({tag, ".mem_arvalid"}, 64'(bus.mem_arvalid), 64'd1);
            chk({tag, ".mem_araddr"}, bus.mem_araddr,
                {a[63:3], 3'b000});
            chk({tag, ".arready_busy"}, 64'(bus.immu_arready), 64'd0);
            bus.mem_arready = 1'b1;
            @(negedge clk);
            bus.mem_arready = 1'b0;
            #1;
            chk({tag, ".mem_rready"}, 64'(bus.mem_rready), 64'd1);
            if (fl) begin
                bus.flush_valid = 1'b1;
                #1 chk({tag, ".flush_ready_r"},
                       64'(bus.flush_ready), 64'd0);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = md;
            bus.mem_rresp  = mr;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
            bus.mem_rresp  = 2'b11;
            #1;
        end else begin
            chk({tag, ".mem_arvalid"}, 64'(bus.mem_arvalid), 64'd0);
        end
        chk({tag, ".rvalid"}, 64'(bus.immu_rvalid), 64'd1);
        chk({tag, ".rdata"}, bus.immu_rdata, ed);
        chk({tag, ".rresp"}, 64'(bus.immu_rresp), 64'(er));
        chk({tag, ".mem_hs"}, 64'(mem_hs - hs0), miss ? 64'd1 : 64'd0);
        if (fl)
            chk({tag, ".flush_ready_resp"},
                64'(bus.flush_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk({tag, ".hold_rvalid"}, 64'(bus.immu_rvalid), 64'd1);
            chk({tag, ".hold_rdata"}, bus.immu_rdata, ed);
            chk({tag, ".hold_rresp"}, 64'(bus.immu_rresp), 64'(er));
        end
        bus.immu_rready = 1'b1;
        @(negedge clk);
        bus.immu_rready = 1'b0;
        #1;
        chk({tag, ".rvalid_done"}, 64'(bus.immu_rvalid), 64'd0);
        if (fl) begin
            chk({tag, ".flush_ready_idle"},
                64'(bus.flush_ready), 64'd1);
            chk({tag, ".arready_fl"}, 64'(bus.immu_arready), 64'd0);
            @(negedge clk);
            bus.flush_valid = 1'b0;
        end
        #1 chk({tag, ".arready_next"}, 64'(bus.immu_arready), 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_hs = 0;
        rst_n = 1'b0;
        bus.immu_arvalid = 1'b0;
        bus.immu_aruser  = 1'b0;
        bus.immu_araddr  = '0;
        bus.immu_rready  = 1'b0;
        bus.flush_valid  = 1'b0;
        bus.mem_arready  = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rresp    = 2'b00;
        bus.mem_rdata    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.rvalid", 64'(bus.immu_rvalid), 64'd0);
        chk("rst.rresp", 64'(bus.immu_rresp), 64'd0);
        chk("rst.rdata", bus.immu_rdata, 64'd0);
        chk("rst.mem_arvalid", 64'(bus.mem_arvalid), 64'd0);
        chk("rst.mem_araddr", bus.mem_araddr, 64'd0);
        chk("rst.mem_rready", 64'(bus.mem_rready), 64'd0);
        chk("rst.arready", 64'(bus.immu_arready), 64'd1);
        chk("rst.flush_ready", 64'(bus.flush_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Miss then hit on the same doubleword.
        do_read("miss", 64'h8000_1000, 1'b0, 1'b1,
                64'h0000_0000_2000_0C01, 2'b00,
                64'h0000_0000_2000_0C01, 2'b00, 0, 1'b0);
        do_read("hit", 64'h8000_1000, 1'b0, 1'b0, '0, 2'b00,
                64'h0000_0000_2000_0C01, 2'b00, 0, 1'b0);

        // Bypass forces a fetch and refills the buffer.
        do_read("bypass", 64'h8000_1000, 1'b1, 1'b1,
                64'h1234_5678_AAAA_0001, 2'b00,
                64'h1234_5678_AAAA_0001, 2'b00, 0, 1'b0);
        do_read("hit2", 64'h8000_1000, 1'b0, 1'b0, '0, 2'b00,
                64'h1234_5678_AAAA_0001, 2'b00, 0, 1'b0);

        // Misaligned: SLVERR, zero data, buffer untouched.
        do_read("misal", 64'h8000_1004, 1'b0, 1'b0, '0, 2'b00,
                64'd0, 2'b10, 0, 1'b0);
        do_read("hit3", 64'h8000_1000, 1'b0, 1'b0, '0, 2'b00,
                64'h1234_5678_AAAA_0001, 2'b00, 0, 1'b0);

        // Memory error invalidates the buffer; retry misses.
        do_read("memerr", 64'h8000_2000, 1'b0, 1'b1,
                64'h0000_0000_0000_DEAD, 2'b10,
                64'h0000_0000_0000_DEAD, 2'b10, 0, 1'b0);
        do_read("err_old", 64'h8000_1000, 1'b0, 1'b1,
                64'h0000_0000_0000_1111, 2'b00,
                64'h0000_0000_0000_1111, 2'b00, 0, 1'b0);
        do_read("err_retry", 64'h8000_2000, 1'b0, 1'b1,
                64'h0000_0000_2000_0801, 2'b00,
                64'h0000_0000_2000_0801, 2'b00, 0, 1'b0);

        // Flush and request together: flush wins, read then misses.
        @(negedge clk);
        bus.flush_valid  = 1'b1;
        bus.immu_arvalid = 1'b1;
        bus.immu_araddr  = 64'h8000_2000;
        #1;
        chk("flush.arready", 64'(bus.immu_arready), 64'd0);
        chk("flush.flush_ready", 64'(bus.flush_ready), 64'd1);
        @(negedge clk);
        bus.flush_valid  = 1'b0;
        bus.immu_arvalid = 1'b0;
        do_read("post_flush", 64'h8000_2000, 1'b0, 1'b1,
                64'h0000_0000_2000_0BBB, 2'b00,
                64'h0000_0000_2000_0BBB, 2'b00, 0, 1'b0);

        // Flush raised in MEM_R waits for IDLE; with backpressure.
        do_read("fl_memr", 64'h8000_3000, 1'b0, 1'b1,
                64'h0000_0000_3000_0C01, 2'b00,
                64'h0000_0000_3000_0C01, 2'b00, 5, 1'b1);
        do_read("fl_after", 64'h8000_3000, 1'b0, 1'b1,
                64'h0000_0000_3000_0C0F, 2'b00,
                64'h0000_0000_3000_0C0F, 2'b00, 0, 1'b0);

        // Reset pulsed in MEM_AR drops mem_arvalid at once.
        @(negedge clk);
        bus.immu_arvalid = 1'b1;
        bus.immu_araddr  = 64'h8000_3000;
        bus.immu_aruser  = 1'b1;
        @(negedge clk);
        bus.immu_arvalid = 1'b0;
        bus.immu_aruser  = 1'b0;
        #1 chk("rstmid.in_ar", 64'(bus.mem_arvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.mem_arvalid", 64'(bus.mem_arvalid), 64'd0);
        chk("rstmid.mem_araddr", bus.mem_araddr, 64'd0);
        chk("rstmid.rdata", bus.immu_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read("rstmid.miss", 64'h8000_3000, 1'b0, 1'b1,
                64'h0000_0000_3000_0D01, 2'b00,
                64'h0000_0000_3000_0D01, 2'b00, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
